// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the async FIFO read-side stream logic.
//   STREAM_BUF_DEPTH : entries in the read-side prefetch buffer.
//   STREAM_PTR_W     : width of the prefetch buffer head/tail/count.
//   ptr_wrap_inc()   : head/tail increment that wraps 2 -> 0.
package fifo_pkg;

   localparam int STREAM_BUF_DEPTH = 3;
   localparam int STREAM_PTR_W     = 2;

   // Pointer advance for a buffer whose depth is not a power of two.
   function automatic logic [STREAM_PTR_W-1:0] ptr_wrap_inc(input logic [STREAM_PTR_W-1:0] p);
      if (p == STREAM_PTR_W'(STREAM_BUF_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/stream_prefetch_buf.sv
// stream_prefetch_buf: 3-entry circular buffer feeding a valid/ready stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data into the tail entry this edge
//   push_data   : word to store
//   ready       : downstream ready; a pop happens on valid && ready
//   valid       : buffer holds at least one word (registered state)
//   data        : word at the head entry (registered state)
//   count       : number of words held (0..3)
module stream_prefetch_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic                    ready,
   output logic                    valid,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [STREAM_PTR_W-1:0] count
);

   logic [DATA_WIDTH-1:0]   mem [STREAM_BUF_DEPTH];
   logic [STREAM_PTR_W-1:0] head;
   logic [STREAM_PTR_W-1:0] tail;
   logic                    pop;

   assign valid = (count != '0);
   assign data  = mem[head];
   assign pop   = valid && ready;

   // Storage is reset too so that data reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STREAM_BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ptr_wrap_inc(tail);
         end
         if (pop) begin
            head <= ptr_wrap_inc(head);
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The upstream issue rule keeps count + inflight <= 3, so a full buffer
   // can never receive a push.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count != STREAM_PTR_W'(STREAM_BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side consumer of the async FIFO (read clock domain).
// Turns the FIFO's registered-read interface into a valid/ready stream with a
// 3-entry prefetch buffer; one word per cycle, and m_ready never reaches
// fifo_r_en combinationally.
//   clk, rst_n  : read clock / asynchronous active-low reset (FIFO r_clk, r_rst_n)
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO data_out, valid the cycle after an accepted read
//   fifo_r_en   : read request to the FIFO
//   m_valid, m_ready, m_data : output stream
//   xfer_count  : completed-transfer count; live only when FIFO_RD_COUNT_EN
//                 is defined, otherwise tied to zero.
//
// Stream handshake: a word transfers on every clk edge where m_valid && m_ready.
// Once m_valid is high, it and m_data stay unchanged until that transfer.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   logic                    inflight;
   logic [STREAM_PTR_W-1:0] buf_count;
   logic [2:0]              outstanding;

   // Words held plus the one possibly on its way; issuing only below the
   // buffer depth guarantees every returning word has a free slot.
   assign outstanding = {1'b0, buf_count} + {2'b00, inflight};
   assign fifo_r_en   = rst_n && !fifo_empty && (outstanding < 3'(STREAM_BUF_DEPTH));

   // fifo_r_en already excludes the empty case, so it equals an accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_r_en;
      end
   end

   stream_prefetch_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_data),
      .ready     (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .count     (buf_count)
   );

`ifdef FIFO_RD_COUNT_EN
   logic pop_fire;
   assign pop_fire = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_count <= '0;
      end else if (pop_fire) begin
         xfer_count <= xfer_count + 1'b1;
      end
   end
`else
   assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_r_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [CW-1:0] xfer_count;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .xfer_count (xfer_count)
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] mem[$];      // FIFO model contents
   logic [DW-1:0] exp_q[$];    // expected stream order
   int            n_cmp = 0;
   int            n_err = 0;
   int            acc_cnt = 0; // accepted FIFO reads since reset
   int            pop_cnt = 0; // stream transfers since reset
   logic [CW-1:0] exp_xfer = '0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Registered-read FIFO model: data_out appears the cycle after an
   // accepted read, empty is a registered flag.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem.delete();
         acc_cnt = 0;
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else begin
         if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem.pop_front();
            acc_cnt++;
         end
         fifo_empty <= (mem.size() == 0);
      end
   end

   // Monitor: samples on the falling edge the values used at the next rise.
   always @(negedge clk) begin
      if (!rst_n) begin
         pop_cnt    = 0;
         exp_xfer   = '0;
         prev_stall = 1'b0;
         exp_q.delete();
      end else begin
         if (fifo_r_en) begin
            check((acc_cnt - pop_cnt) < 3, "ren_limit", acc_cnt - pop_cnt, 2);
         end
`ifdef FIFO_RD_COUNT_EN
         check(xfer_count == exp_xfer, "xfer_count", int'(xfer_count), int'(exp_xfer));
`else
         check(xfer_count == '0, "xfer_count_tied", int'(xfer_count), 0);
`endif
         if (prev_stall) begin
            check(m_valid == 1'b1, "hold_valid", int'(m_valid), 1);
            check(m_data == prev_data, "hold_data", int'(m_data), int'(prev_data));
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_word", int'(m_data), 0);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               check(m_data == e, "stream_data", int'(m_data), int'(e));
            end
            pop_cnt++;
            exp_xfer = exp_xfer + 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fifo_write(input logic [DW-1:0] d);
      mem.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(n < budget, "drain_timeout", n, budget);
   endtask

   // ---------------- stimulus ----------------
   logic [DW-1:0] vec5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   initial begin
      int acc0;
      int ren_t;
      int val_t;
      int t;
      int pops;
      int pop_t [5];

      // Reset with the FIFO empty.
      repeat (3) begin
         @(negedge clk);
         check(fifo_r_en == 1'b0, "rst_ren", int'(fifo_r_en), 0);
         check(m_valid == 1'b0, "rst_valid", int'(m_valid), 0);
         check(m_data == '0, "rst_data", int'(m_data), 0);
         check(xfer_count == '0, "rst_xfer", int'(xfer_count), 0);
      end
      step();
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check(fifo_r_en == 1'b0, "idle_ren", int'(fifo_r_en), 0);
         check(m_valid == 1'b0, "idle_valid", int'(m_valid), 0);
      end

      // Preloaded burst with m_ready high: 2-cycle startup, then one per cycle.
      step();
      m_ready = 1'b1;
      foreach (vec5[i]) fifo_write(vec5[i]);
      ren_t = -1; val_t = -1; t = 0; pops = 0;
      while (pops < 5 && t < 40) begin
         @(negedge clk);
         t++;
         if (fifo_r_en && ren_t < 0) ren_t = t;
         if (m_valid && val_t < 0) val_t = t;
         if (m_valid && m_ready) begin
            pop_t[pops] = t;
            pops++;
         end
      end
      check(pops == 5, "burst_pops", pops, 5);
      check(val_t - ren_t == 2, "startup_latency", val_t - ren_t, 2);
      check(pop_t[4] - pop_t[0] == 4, "burst_back_to_back", pop_t[4] - pop_t[0], 4);
      wait_drain(20);

      // Backpressure: only 3 reads while stalled, head word held.
      step();
      m_ready = 1'b0;
      acc0 = acc_cnt;
      foreach (vec5[i]) fifo_write(vec5[i]);
      repeat (10) step();
      @(negedge clk);
      check(acc_cnt - acc0 == 3, "stall_reads", acc_cnt - acc0, 3);
      check(m_valid == 1'b1, "stall_valid", int'(m_valid), 1);
      check(m_data == 8'h11, "stall_head", int'(m_data), 8'h11);
      step();
      m_ready = 1'b1;
      wait_drain(30);
      check(acc_cnt - acc0 == 5, "stall_total_reads", acc_cnt - acc0, 5);

      // Toggling ready with the FIFO refilled every cycle.
      for (int i = 0; i < 12; i++) begin
         step();
         fifo_write(DW'(8'h60 + i));
         m_ready = (i % 2 == 0);
      end
      step();
      m_ready = 1'b1;
      wait_drain(60);

      // Single word, then the FIFO stays empty.
      step();
      acc0 = acc_cnt;
      fifo_write(8'hA5);
      wait_drain(20);
      repeat (5) begin
         @(negedge clk);
         check(m_valid == 1'b0, "single_valid_low", int'(m_valid), 0);
         check(fifo_r_en == 1'b0, "single_no_ren", int'(fifo_r_en), 0);
      end
      check(acc_cnt - acc0 == 1, "single_reads", acc_cnt - acc0, 1);

      // Reset with two words buffered and one read in flight.
      step();
      m_ready = 1'b0;
      foreach (vec5[i]) fifo_write(DW'(8'hC0 + i));
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!m_valid && t < 20);
      check(m_valid == 1'b1, "pre_reset_valid", int'(m_valid), 1);
      step();
      rst_n = 1'b0;
      #1;
      check(m_valid == 1'b0, "mid_rst_valid", int'(m_valid), 0);
      check(m_data == '0, "mid_rst_data", int'(m_data), 0);
      check(fifo_r_en == 1'b0, "mid_rst_ren", int'(fifo_r_en), 0);
      check(xfer_count == '0, "mid_rst_xfer", int'(xfer_count), 0);
      repeat (2) @(negedge clk);
      step();
      rst_n = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) fifo_write(DW'(8'hD1 + i));
      wait_drain(30);
      @(negedge clk);
`ifdef FIFO_RD_COUNT_EN
      check(xfer_count == 16'd4, "post_rst_xfer", int'(xfer_count), 4);
`else
      check(xfer_count == '0, "post_rst_xfer", int'(xfer_count), 0);
`endif
      check(exp_q.size() == 0, "leftover_words", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
